// File: rtl/arb_requester.sv
// Per-channel command queue that requests an external arbiter and
// streams one BURST_LEN-beat burst per grant on the downstream port.
module arb_requester #(
    parameter int BURST_LEN = 4,
    parameter int DEPTH     = 7
) (
    input  logic       arb_clk,
    input  logic       arb_rst,
    input  logic       cmd_vld,
    input  logic [1:0] cmd_ch,
    output logic       cmd_rdy,
    output logic       arb_req0,
    output logic       arb_req1,
    output logic       arb_req2,
    output logic       arb_req3,
    input  logic [1:0] arb_gnt,
    input  logic       arb_gnt_vld,
    output logic       out_vld,
    output logic [1:0] out_ch,
    output logic [3:0] out_beat,
    output logic       out_last,
    input  logic       out_rdy,
    output logic       busy,
    output logic       gnt_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        RLS
    } state_t;

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);
    localparam logic [3:0] LAST_C  = 4'(BURST_LEN - 1);

    state_t     state_q, state_d;
    logic [3:0] pend_q [4];
    logic [3:0] pend_d [4];
    logic [1:0] ch_q, ch_d;
    logic [3:0] beat_q, beat_d;
    logic       err_q, err_d;
    logic       accept;
    logic       done;
    logic       any_pend;

    assign cmd_rdy  = (pend_q[cmd_ch] != DEPTH_C);
    assign accept   = cmd_vld && cmd_rdy;
    assign any_pend = (pend_q[0] != 4'd0) || (pend_q[1] != 4'd0) ||
                      (pend_q[2] != 4'd0) || (pend_q[3] != 4'd0);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        beat_d  = beat_q;
        err_d   = err_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_pend) state_d = REQ;
            end
            REQ: begin
                if (arb_gnt_vld) begin
                    if (pend_q[arb_gnt] != 4'd0) begin
                        ch_d    = arb_gnt;
                        beat_d  = 4'd0;
                        state_d = XFER;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            XFER: begin
                if (out_rdy) begin
                    if (beat_q == LAST_C) begin
                        done    = 1'b1;
                        beat_d  = 4'd0;
                        state_d = RLS;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end
            end
            RLS: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accept and burst-end on the same channel cancel out.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pend_d[i] = pend_q[i];
            if (accept && (cmd_ch == 2'(i)) && !(done && (ch_q == 2'(i))))
                pend_d[i] = pend_q[i] + 4'd1;
            else if (done && (ch_q == 2'(i)) && !(accept && (cmd_ch == 2'(i))))
                pend_d[i] = pend_q[i] - 4'd1;
        end
    end

    always_ff @(posedge arb_clk) begin
        if (arb_rst) begin
            state_q <= IDLE;
            ch_q    <= 2'd0;
            beat_q  <= 4'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) pend_q[i] <= 4'd0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            for (int i = 0; i < 4; i++) pend_q[i] <= pend_d[i];
        end
    end

    assign arb_req0 = (state_q == REQ) && (pend_q[0] != 4'd0);
    assign arb_req1 = (state_q == REQ) && (pend_q[1] != 4'd0);
    assign arb_req2 = (state_q == REQ) && (pend_q[2] != 4'd0);
    assign arb_req3 = (state_q == REQ) && (pend_q[3] != 4'd0);
    assign out_vld  = (state_q == XFER);
    assign out_ch   = ch_q;
    assign out_beat = beat_q;
    assign out_last = out_vld && (beat_q == LAST_C);
    assign busy     = (state_q != IDLE);
    assign gnt_err  = err_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_arb_requester;

    localparam int BL    = 4;
    localparam int DEPTH = 7;

    logic       arb_clk = 1'b0;
    logic       arb_rst = 1'b0;
    logic       cmd_vld = 1'b0;
    logic [1:0] cmd_ch = 2'd0;
    logic       cmd_rdy;
    logic       arb_req0, arb_req1, arb_req2, arb_req3;
    logic [1:0] arb_gnt = 2'd0;
    logic       arb_gnt_vld = 1'b0;
    logic       out_vld;
    logic [1:0] out_ch;
    logic [3:0] out_beat;
    logic       out_last;
    logic       out_rdy = 1'b0;
    logic       busy;
    logic       gnt_err;
    logic [3:0] reqv;

    int vectors = 0;
    int miscompares = 0;

    assign reqv = {arb_req3, arb_req2, arb_req1, arb_req0};

    arb_requester #(.BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .arb_clk(arb_clk), .arb_rst(arb_rst),
        .cmd_vld(cmd_vld), .cmd_ch(cmd_ch), .cmd_rdy(cmd_rdy),
        .arb_req0(arb_req0), .arb_req1(arb_req1),
        .arb_req2(arb_req2), .arb_req3(arb_req3),
        .arb_gnt(arb_gnt), .arb_gnt_vld(arb_gnt_vld),
        .out_vld(out_vld), .out_ch(out_ch), .out_beat(out_beat),
        .out_last(out_last), .out_rdy(out_rdy),
        .busy(busy), .gnt_err(gnt_err)
    );

    always #5 arb_clk = ~arb_clk;

    // Reference model: queue depths, a "wants arbiter" flag, the burst
    // in flight (-1 = none) and a one-cycle release gap after each burst.
    int m_pend[4];
    bit m_reqing;
    int m_bch;
    int m_ch;
    int m_beat;
    bit m_cool;
    bit m_err;

    function automatic void model_step();
        int np[4];
        int tot;
        bit acc;
        if (arb_rst) begin
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_reqing = 0; m_bch = -1; m_ch = 0;
            m_beat = 0; m_cool = 0; m_err = 0;
            return;
        end
        np = m_pend;
        acc = cmd_vld && (m_pend[cmd_ch] != DEPTH);
        tot = 0;
        for (int i = 0; i < 4; i++) tot += m_pend[i];
        if (m_bch >= 0) begin
            if (out_rdy) begin
                if (m_beat == BL - 1) begin
                    np[m_bch] = np[m_bch] - 1;
                    m_bch = -1; m_beat = 0; m_cool = 1;
                end else begin
                    m_beat++;
                end
            end
        end else if (m_reqing) begin
            if (arb_gnt_vld) begin
                if (m_pend[arb_gnt] != 0) begin
                    m_bch = int'(arb_gnt); m_ch = int'(arb_gnt);
                    m_beat = 0; m_reqing = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (tot != 0) begin
            m_reqing = 1;
        end
        if (acc) np[cmd_ch] = np[cmd_ch] + 1;
        m_pend = np;
    endfunction

    function automatic logic [14:0] exp_vec();
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = m_reqing && (m_pend[n] != 0);
        return {1'(m_pend[cmd_ch] != DEPTH), r, 1'(m_bch >= 0), 2'(m_ch),
                4'(m_beat), 1'((m_bch >= 0) && (m_beat == BL - 1)),
                1'(m_reqing || (m_bch >= 0) || m_cool), m_err};
    endfunction

    task automatic tick();
        @(posedge arb_clk);
        model_step();
        #2;
    endtask

    task automatic do_reset();
        cmd_vld = 0; cmd_ch = 0; arb_gnt_vld = 0; arb_gnt = 0; out_rdy = 0;
        arb_rst = 1;
        tick();
        arb_rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err}
            !== 15'b1_0000_0_00_0000_0_0_0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want %b",
                {cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err},
                15'b1_0000_0_00_0000_0_0_0);
        end
    endtask

    task automatic test_single();
        do_reset();
        cmd_vld = 1; cmd_ch = 2;
        tick();
        cmd_vld = 0;
        tick();
        #1;
        vectors++;
        if ({busy, reqv} !== 5'b1_0100) begin
            miscompares++;
            $display("FAIL single_req got %b want %b", {busy, reqv}, 5'b1_0100);
        end
        arb_gnt = 2; arb_gnt_vld = 1; out_rdy = 1;
        tick();
        arb_gnt_vld = 0;
        for (int i = 0; i < BL; i++) begin
            #1;
            vectors++;
            if ({out_vld, out_ch, out_beat, out_last} !==
                {1'b1, 2'd2, 4'(i), 1'(i == BL - 1)}) begin
                miscompares++;
                $display("FAIL single_beat%0d got %b want %b", i,
                    {out_vld, out_ch, out_beat, out_last},
                    {1'b1, 2'd2, 4'(i), 1'(i == BL - 1)});
            end
            tick();
        end
        #1;
        vectors++;
        if ({busy, out_vld, reqv} !== 6'b1_0_0000) begin
            miscompares++;
            $display("FAIL single_rls got %b want %b", {busy, out_vld, reqv}, 6'b100000);
        end
        tick();
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle busy got %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int got[$];
        int stall;
        stall = 0;
        do_reset();
        cmd_vld = 1; cmd_ch = 1;
        tick();
        cmd_vld = 0;
        tick();
        arb_gnt = 1; arb_gnt_vld = 1;
        tick();
        arb_gnt_vld = 0;
        for (int c = 0; c < 20 && got.size() < BL; c++) begin
            if (out_vld && (out_beat == 4'd1) && (stall < 3)) begin
                out_rdy = 0;
                stall++;
                #1;
                vectors++;
                if ({out_vld, out_ch, out_beat} !== {1'b1, 2'd1, 4'd1}) begin
                    miscompares++;
                    $display("FAIL bp_hold got %b want %b",
                        {out_vld, out_ch, out_beat}, {1'b1, 2'd1, 4'd1});
                end
            end else begin
                out_rdy = 1;
                #1;
                if (out_vld) got.push_back(int'(out_beat));
            end
            tick();
        end
        out_rdy = 0;
        vectors++;
        if (got.size() != BL || stall != 3) begin
            miscompares++;
            $display("FAIL bp_count beats %0d stalls %0d want %0d and 3",
                got.size(), stall, BL);
        end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] != i) begin
                miscompares++;
                $display("FAIL bp_order idx %0d got %0d want %0d", i, got[i], i);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        cmd_ch = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cmd_vld = 1;
            #1;
            vectors++;
            if (cmd_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_rdy%0d got %b want 1", i, cmd_rdy);
            end
            tick();
        end
        #1;
        vectors++;
        if (cmd_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full got %b want 0", cmd_rdy);
        end
        tick();
        #1;
        vectors++;
        if ({cmd_rdy, arb_req0} !== 2'b01) begin
            miscompares++;
            $display("FAIL fill_no_wrap got %b want 01", {cmd_rdy, arb_req0});
        end
        cmd_ch = 1;
        #1;
        vectors++;
        if (cmd_rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_ch1_rdy got %b want 1", cmd_rdy);
        end
        tick();
        cmd_vld = 0;
        #1;
        vectors++;
        if (reqv !== 4'b0011) begin
            miscompares++;
            $display("FAIL fill_reqs got %b want 0011", reqv);
        end
    endtask

    task automatic test_bad_grant();
        do_reset();
        cmd_vld = 1; cmd_ch = 1;
        tick();
        cmd_vld = 0;
        tick();
        arb_gnt = 3; arb_gnt_vld = 1;
        tick();
        arb_gnt_vld = 0;
        #1;
        vectors++;
        if ({gnt_err, out_vld, reqv} !== 6'b1_0_0010) begin
            miscompares++;
            $display("FAIL badgnt_err got %b want %b", {gnt_err, out_vld, reqv}, 6'b100010);
        end
        arb_gnt = 1; arb_gnt_vld = 1; out_rdy = 1;
        tick();
        arb_gnt_vld = 0;
        for (int i = 0; i < BL; i++) begin
            #1;
            vectors++;
            if ({out_vld, out_ch, out_beat, gnt_err} !== {1'b1, 2'd1, 4'(i), 1'b1}) begin
                miscompares++;
                $display("FAIL badgnt_beat%0d got %b want %b", i,
                    {out_vld, out_ch, out_beat, gnt_err}, {1'b1, 2'd1, 4'(i), 1'b1});
            end
            tick();
        end
        out_rdy = 0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        cmd_vld = 1; cmd_ch = 0;
        tick();
        cmd_vld = 0;
        tick();
        arb_gnt = 0; arb_gnt_vld = 1; out_rdy = 1;
        tick();
        arb_gnt = 3;
        for (int i = 0; i < BL; i++) begin
            if (i == BL - 1) cmd_vld = 1;
            tick();
        end
        cmd_vld = 0;
        #1;
        vectors++;
        if ({out_vld, reqv} !== 5'b0_0000) begin
            miscompares++;
            $display("FAIL same_rls got %b want 00000", {out_vld, reqv});
        end
        tick();
        arb_gnt_vld = 0;
        tick();
        #1;
        vectors++;
        if ({reqv, gnt_err, busy} !== 6'b0001_0_1) begin
            miscompares++;
            $display("FAIL same_rereq got %b want 000101", {reqv, gnt_err, busy});
        end
        out_rdy = 0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        cmd_vld = 1; cmd_ch = 3;
        tick();
        cmd_ch = 1;
        tick();
        cmd_vld = 0; cmd_ch = 0;
        arb_gnt = 3; arb_gnt_vld = 1; out_rdy = 1;
        tick();
        arb_gnt_vld = 0;
        tick();
        tick();
        #1;
        vectors++;
        if ({out_vld, out_ch, out_beat} !== {1'b1, 2'd3, 4'd2}) begin
            miscompares++;
            $display("FAIL midrst_pre got %b want %b",
                {out_vld, out_ch, out_beat}, {1'b1, 2'd3, 4'd2});
        end
        arb_rst = 1;
        tick();
        arb_rst = 0;
        #1;
        vectors++;
        if ({cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err}
            !== 15'b1_0000_0_00_0000_0_0_0) begin
            miscompares++;
            $display("FAIL midrst_post got %b want %b",
                {cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err},
                15'b1_0000_0_00_0000_0_0_0);
        end
        for (int i = 0; i < 3; i++) tick();
        #1;
        vectors++;
        if ({busy, reqv, out_vld} !== 6'b0) begin
            miscompares++;
            $display("FAIL midrst_quiet got %b want 000000", {busy, reqv, out_vld});
        end
        out_rdy = 0;
    endtask

    task automatic test_random();
        int base;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            arb_rst = ($urandom_range(0, 249) == 0);
            cmd_vld = 1'($urandom_range(0, 1));
            cmd_ch = 2'($urandom_range(0, 3));
            out_rdy = ($urandom_range(0, 3) != 0);
            arb_gnt_vld = ($urandom_range(0, 2) == 0);
            arb_gnt = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                base = $urandom_range(0, 3);
                for (int k = 0; k < 4; k++) begin
                    if (m_pend[(base + k) % 4] != 0) begin
                        arb_gnt = 2'((base + k) % 4);
                        break;
                    end
                end
            end
            #1;
            vectors++;
            if ({cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err}
                !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_cyc%0d got %b want %b", n,
                    {cmd_rdy, reqv, out_vld, out_ch, out_beat, out_last, busy, gnt_err},
                    exp_vec());
            end
            tick();
        end
        arb_rst = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill();
        test_bad_grant();
        test_same_cycle();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter BURST_LEN, default 4, SHALL set the number of data beats per grant (range 1..16).
REQ-002 Parameter DEPTH, default 7, SHALL set the maximum pending commands per channel (range 1..15).
REQ-003 arb_clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 arb_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cmd_vld  input  1  SHALL indicate a command request for channel cmd_ch.
REQ-006 cmd_ch  input  2  SHALL select the target channel (0..3) of the command.
REQ-007 cmd_rdy  output  1  SHALL indicate that cmd_ch can accept a command this cycle.
REQ-008 arb_req0..arb_req3  output  1 each  SHALL be the request lines to the arbiter.
REQ-009 arb_gnt  input  2  SHALL be the index of the granted channel.
REQ-010 arb_gnt_vld  input  1  SHALL qualify arb_gnt.
REQ-011 out_vld  output  1  SHALL indicate a valid data beat.
REQ-012 out_ch  output  2  SHALL give the channel that owns the current beat.
REQ-013 out_beat  output  4  SHALL give the beat index within the burst, 0-based.
REQ-014 out_last  output  1  SHALL mark beat BURST_LEN-1.
REQ-015 out_rdy  input  1  SHALL be the downstream accept for the beat.
REQ-016 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-017 gnt_err  output  1  SHALL be a sticky flag for an illegal grant.

Function
REQ-018 Per channel, a pending counter (4 bits, 0..DEPTH) SHALL track queued commands.
REQ-019 cmd_rdy SHALL equal (pending[cmd_ch] != DEPTH), decoded combinationally.
REQ-020 A command SHALL be accepted when cmd_vld && cmd_rdy, and pending[cmd_ch] SHALL increment on the next edge.
REQ-021 The FSM SHALL have the states IDLE, REQ, XFER and RLS.
REQ-022 IDLE: if any pending != 0, next state SHALL be REQ; otherwise it SHALL stay in IDLE.
REQ-023 arb_reqN SHALL equal (state==REQ) && (pending[N] != 0), decoded from registers only.
REQ-024 REQ: on arb_gnt_vld with pending[arb_gnt] != 0, the block SHALL latch the channel, clear the beat counter, and go to XFER.
REQ-025 REQ: on arb_gnt_vld with pending[arb_gnt] == 0, the block SHALL set gnt_err, ignore the grant, and stay in REQ.
REQ-026 REQ: with no arb_gnt_vld, the block SHALL stay in REQ with the requests held.
REQ-027 XFER: out_vld SHALL be 1, out_ch SHALL be the latched channel, and out_beat SHALL be the beat counter.
REQ-028 XFER: on out_vld && out_rdy, the beat counter SHALL increment; with out_rdy low, all outputs SHALL hold.
REQ-029 XFER: the handshake on beat BURST_LEN-1 SHALL decrement pending[ch] and move to RLS.
REQ-030 RLS: all arb_reqN and out_vld SHALL be 0 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-031 First grant to first beat latency SHALL be 1 cycle.
REQ-032 Minimum cycles per burst, grant to next possible request, SHALL be BURST_LEN+3.
REQ-033 A command accept and a burst-end decrement on the same channel in the same cycle SHALL leave pending unchanged.
REQ-034 The pending counter SHALL never exceed DEPTH or wrap below 0.
REQ-035 A new arb_gnt_vld seen outside REQ SHALL be ignored and SHALL NOT set gnt_err.
REQ-036 out_last SHALL equal out_vld && (out_beat == BURST_LEN-1).

Reset
REQ-037 When arb_rst is sampled high, the block SHALL clear all pending counters, the beat counter, the latched channel and gnt_err, and enter IDLE.
REQ-038 After reset, all outputs SHALL be 0 except cmd_rdy, which SHALL be 1.
REQ-039 Reset asserted mid-burst SHALL abort the burst; out_vld SHALL be 0 from the next cycle, and the aborted command SHALL be lost.

Verification
REQ-040 Single command, ch2, out_rdy=1, BURST_LEN=4 -> arb_req2=1 only; after grant 2, beats 0..3 on ch2; out_last on beat 3; busy low 2 cycles after the last beat.
REQ-041 Backpressure: out_rdy low for 3 cycles at beat 1 -> beat 1 held stable; 4 beats total; no duplicate or skipped beat.
REQ-042 Fill ch0 with 7 commands -> cmd_rdy=0 for ch0 while ch1 still accepts; an 8th cmd_vld on ch0 leaves pending=7.
REQ-043 Grant 3 while only ch1 is pending -> gnt_err=1, no beats, arb_req1 stays high; a subsequent grant 1 completes normally with gnt_err still 1.
REQ-044 Same-cycle accept on ch0 and final-beat handshake of a ch0 burst, pending=1 -> pending stays 1; arb_req0 reasserts after RLS/IDLE.
REQ-045 arb_rst pulsed at beat 2 of a burst -> all outputs are reset values next cycle, pending is 0 everywhere, no further requests.
